// File: rtl/multicycle_control_fsm.sv
// Moore control sequencer for the multicycle RV32I datapath (lw, sw, R, I, beq, jal).
// Optional memory wait states are enabled by defining MCU_MEM_WAIT_EN (adds MemReady).
module multicycle_control_fsm #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         Op,
    input  logic               Zero,
`ifdef MCU_MEM_WAIT_EN
    input  logic               MemReady,
`endif
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic               RegWrite,
    output logic [1:0]         ImmSrc,
    output logic [STATE_W-1:0] State
);

    localparam logic [STATE_W-1:0] S_FETCH    = STATE_W'(0);
    localparam logic [STATE_W-1:0] S_DECODE   = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_MEMADR   = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_MEMREAD  = STATE_W'(3);
    localparam logic [STATE_W-1:0] S_MEMWB    = STATE_W'(4);
    localparam logic [STATE_W-1:0] S_MEMWRITE = STATE_W'(5);
    localparam logic [STATE_W-1:0] S_EXECUTER = STATE_W'(6);
    localparam logic [STATE_W-1:0] S_ALUWB    = STATE_W'(7);
    localparam logic [STATE_W-1:0] S_EXECUTEI = STATE_W'(8);
    localparam logic [STATE_W-1:0] S_JAL      = STATE_W'(9);
    localparam logic [STATE_W-1:0] S_BEQ      = STATE_W'(10);

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    logic [STATE_W-1:0] state_q, state_d;
    logic               mem_ready;

    logic               pc_update, branch, adr_src, mem_write, ir_write, reg_write;
    logic [1:0]         result_src, alu_src_a, alu_src_b, alu_op;

`ifdef MCU_MEM_WAIT_EN
    assign mem_ready = MemReady;
`else
    assign mem_ready = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTER;
                    OP_ITYPE:     state_d = S_EXECUTEI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
            S_EXECUTER, S_EXECUTEI, S_JAL: state_d = S_ALUWB;
            S_ALUWB, S_BEQ: state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Unlisted fields stay 0, which also makes the unused encodings inert.
    always_comb begin
        pc_update  = 1'b0;
        branch     = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        case (state_q)
            S_FETCH: begin
                ir_write   = mem_ready;
                pc_update  = mem_ready;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD:  adr_src = 1'b1;
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            S_EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            S_ALUWB:    reg_write = 1'b1;
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (Op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    // Enables are gated by rst_n so an asynchronous reset kills any write in flight at once.
    assign PCWrite   = rst_n & ((Zero & branch) | pc_update);
    assign IRWrite   = rst_n & ir_write;
    assign MemWrite  = rst_n & mem_write;
    assign RegWrite  = rst_n & reg_write;
    assign AdrSrc    = adr_src;
    assign ResultSrc = result_src;
    assign ALUSrcA   = alu_src_a;
    assign ALUSrcB   = alu_src_b;
    assign ALUOp     = alu_op;
    assign State     = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: directed plan steps plus randomized
// instruction streams checked against a per-instruction state-sequence model.
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] Op;
    logic       Zero;
`ifdef MCU_MEM_WAIT_EN
    logic       MemReady = 1'b1;
`endif
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
    logic [3:0] State;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, JL = 7'b1101111, BQ = 7'b1100011;

    typedef struct packed {
        logic       adr, mw, irw;
        logic [1:0] rs, sa, sb, op;
        logic       rw, pcu, br;
    } exp_t;

    exp_t tbl [0:10];

    multicycle_control_fsm #(.STATE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .Op(Op), .Zero(Zero),
`ifdef MCU_MEM_WAIT_EN
        .MemReady(MemReady),
`endif
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .RegWrite(RegWrite), .ImmSrc(ImmSrc), .State(State)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] immModel(input logic [6:0] op);
        if (op == SW) return 2'b01;
        if (op == BQ) return 2'b10;
        if (op == JL) return 2'b11;
        return 2'b00;
    endfunction

    // Runs one instruction from FETCH, checking every cycle; zmode 0/1 fixes Zero, 2 randomizes it.
    task automatic applyStimulus(input logic [6:0] op, input int zmode, input int maxCycles);
        int   seq[$];
        exp_t e;
        case (op)
            LW:      seq = '{0, 1, 2, 3, 4};
            SW:      seq = '{0, 1, 2, 5};
            RT:      seq = '{0, 1, 6, 7};
            IT:      seq = '{0, 1, 8, 7};
            JL:      seq = '{0, 1, 9, 7};
            BQ:      seq = '{0, 1, 10};
            default: seq = '{0, 1};
        endcase
        Op = op;
        for (int i = 0; i < seq.size() && i < maxCycles; i++) begin
            Zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            @(negedge clk);
            e = tbl[seq[i]];
            checkOutput($sformatf("state op=%b c%0d", op, i), 8'(State), 8'(seq[i]));
            checkOutput("PCWrite", 8'(PCWrite), 8'(e.pcu | (e.br & Zero)));
            checkOutput("AdrSrc", 8'(AdrSrc), 8'(e.adr));
            checkOutput("MemWrite", 8'(MemWrite), 8'(e.mw));
            checkOutput("IRWrite", 8'(IRWrite), 8'(e.irw));
            checkOutput("RegWrite", 8'(RegWrite), 8'(e.rw));
            checkOutput("ResultSrc", 8'(ResultSrc), 8'(e.rs));
            checkOutput("ALUSrcA", 8'(ALUSrcA), 8'(e.sa));
            checkOutput("ALUSrcB", 8'(ALUSrcB), 8'(e.sb));
            checkOutput("ALUOp", 8'(ALUOp), 8'(e.op));
            checkOutput("ImmSrc", 8'(ImmSrc), 8'(immModel(op)));
            checkOutput("MemWrite&RegWrite", 8'(MemWrite & RegWrite), 8'd0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " State"}, 8'(State), 8'd0);
        checkOutput({tag, " PCWrite"}, 8'(PCWrite), 8'd0);
        checkOutput({tag, " IRWrite"}, 8'(IRWrite), 8'd0);
        checkOutput({tag, " MemWrite"}, 8'(MemWrite), 8'd0);
        checkOutput({tag, " RegWrite"}, 8'(RegWrite), 8'd0);
        checkOutput({tag, " ALUSrcB"}, 8'(ALUSrcB), 8'd2);
        checkOutput({tag, " ResultSrc"}, 8'(ResultSrc), 8'd2);
    endtask

    initial begin
        logic [6:0] ops [0:5];
        logic [6:0] r;
        ops = '{LW, SW, RT, IT, JL, BQ};

        tbl[0]  = '{adr:0, mw:0, irw:1, rs:2, sa:0, sb:2, op:0, rw:0, pcu:1, br:0};
        tbl[1]  = '{adr:0, mw:0, irw:0, rs:0, sa:1, sb:1, op:0, rw:0, pcu:0, br:0};
        tbl[2]  = '{adr:0, mw:0, irw:0, rs:0, sa:2, sb:1, op:0, rw:0, pcu:0, br:0};
        tbl[3]  = '{adr:1, mw:0, irw:0, rs:0, sa:0, sb:0, op:0, rw:0, pcu:0, br:0};
        tbl[4]  = '{adr:0, mw:0, irw:0, rs:1, sa:0, sb:0, op:0, rw:1, pcu:0, br:0};
        tbl[5]  = '{adr:1, mw:1, irw:0, rs:0, sa:0, sb:0, op:0, rw:0, pcu:0, br:0};
        tbl[6]  = '{adr:0, mw:0, irw:0, rs:0, sa:2, sb:0, op:2, rw:0, pcu:0, br:0};
        tbl[7]  = '{adr:0, mw:0, irw:0, rs:0, sa:0, sb:0, op:0, rw:1, pcu:0, br:0};
        tbl[8]  = '{adr:0, mw:0, irw:0, rs:0, sa:2, sb:1, op:2, rw:0, pcu:0, br:0};
        tbl[9]  = '{adr:0, mw:0, irw:0, rs:0, sa:1, sb:2, op:0, rw:0, pcu:1, br:0};
        tbl[10] = '{adr:0, mw:0, irw:0, rs:0, sa:2, sb:0, op:1, rw:0, pcu:0, br:1};

        rst_n = 1'b0;
        Op    = LW;
        Zero  = 1'b1;
        @(negedge clk);
        checkResetValues("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] directed instruction classes");
        applyStimulus(LW, 2, 99);
        applyStimulus(LW, 2, 99);
        applyStimulus(SW, 2, 99);
        applyStimulus(BQ, 1, 99);
        applyStimulus(BQ, 0, 99);
        applyStimulus(JL, 2, 99);
        applyStimulus(RT, 2, 99);
        applyStimulus(IT, 2, 99);
        applyStimulus(7'b1111111, 2, 99);

        $display("[TB] asynchronous reset during MEMWRITE");
        applyStimulus(SW, 2, 3);
        #1;
        checkOutput("abort pre State", 8'(State), 8'd5);
        checkOutput("abort pre MemWrite", 8'(MemWrite), 8'd1);
        #1 rst_n = 1'b0;
        #1;
        checkResetValues("abort");
        @(posedge clk);
        @(negedge clk);
        checkResetValues("abort held");
        @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(JL, 2, 99);

`ifdef MCU_MEM_WAIT_EN
        $display("[TB] FETCH wait states");
        MemReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("stall State", 8'(State), 8'd0);
            checkOutput("stall PCWrite", 8'(PCWrite), 8'd0);
            checkOutput("stall IRWrite", 8'(IRWrite), 8'd0);
            @(posedge clk);
            #1;
        end
        MemReady = 1'b1;
        applyStimulus(LW, 2, 99);
`endif

        $display("[TB] randomized instruction stream");
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                do r = 7'($urandom); while (r == LW || r == SW || r == RT || r == IT || r == JL || r == BQ);
            end else begin
                r = ops[$urandom_range(0, 5)];
            end
            applyStimulus(r, 2, 99);
        end
        @(negedge clk);
        checkOutput("final State", 8'(State), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Moore-style control sequencer for the multicycle RV32I core variant.
- Replaces the single-cycle main decoder: steps one shared ALU/memory datapath through Fetch, Decode and per-class execute states.
- Supports lw, sw, R-type, I-type ALU, beq and jal.
- Sits beside the existing ALU decoder, which consumes ALUOp, and drives all datapath mux and write enables.

Parameters:
- STATE_W, 4, width of the state register and of the debug State output (11 states used).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- Op  input  7  opcode field from the instruction register (stable from the end of FETCH onward)
- Zero  input  1  ALU zero flag
- PCWrite  output  1  PC register enable = (Zero & Branch) | PCUpdate
- AdrSrc  output  1  memory address mux: 0=PC, 1=ALUOut
- MemWrite  output  1  data-memory write enable
- IRWrite  output  1  instruction register / OldPC enable
- ResultSrc  output  2  result mux: 00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  output  2  ALU A mux: 00=PC, 01=OldPC, 10=RD1 register
- ALUSrcB  output  2  ALU B mux: 00=WriteData register, 01=ImmExt, 10=constant 4
- ALUOp  output  2  to ALU decoder: 00=add, 01=sub/compare, 10=funct-decoded
- RegWrite  output  1  register-file write enable
- ImmSrc  output  2  combinational from Op: sw=01, beq=10, jal=11, else 00
- State  output  STATE_W  current state (debug/verification)

Behaviour:
- State encoding:
  - FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5
  - EXECUTER=6, ALUWB=7, EXECUTEI=8, JAL=9, BEQ=10
- Reset: rst_n low asynchronously forces State=FETCH. While rst_n is low, PCWrite, IRWrite, RegWrite and MemWrite are forced to 0. All other outputs show their FETCH values. The first FETCH cycle with enables active is the first clock edge after rst_n rises.
- Outputs decode from the state only, except ImmSrc (from Op) and PCWrite (uses Zero). Any field not listed for a state is 0.
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch/jump target computed)
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00
  - MEMREAD: AdrSrc=1, ResultSrc=00
  - MEMWB: ResultSrc=01, RegWrite=1
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10
  - ALUWB: ResultSrc=00, RegWrite=1
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1
- Transitions:
  - FETCH->DECODE.
  - DECODE by Op: 0000011/0100011->MEMADR; 0110011->EXECUTER; 0010011->EXECUTEI; 1101111->JAL; 1100011->BEQ; any other opcode->FETCH (instruction skipped, PC already advanced, no writes).
  - MEMADR: Op=0000011->MEMREAD, else MEMWRITE.
  - MEMREAD->MEMWB.
  - EXECUTER, EXECUTEI, JAL->ALUWB.
  - MEMWB, MEMWRITE, ALUWB, BEQ->FETCH.
  - Unused encodings 11-15->FETCH with all enables 0.
- Latency per instruction: lw 5 cycles; sw, R, I and jal 4; beq 3.
- PCWrite asserts only in FETCH, JAL, or BEQ with Zero=1. MemWrite and RegWrite are never high in the same cycle.
- rst_n asserted mid-instruction aborts it immediately; no partial write completes after the asynchronous assertion.

Optional Feature:
- Macro MCU_MEM_WAIT_EN.
- When defined:
  - Adds input MemReady (1 bit).
  - FETCH, MEMREAD and MEMWRITE hold their state, with all outputs held, while MemReady=0.
  - PCWrite and IRWrite are gated by MemReady in FETCH; MemWrite is asserted for every cycle spent in MEMWRITE.
  - The transition out of each of these states occurs on the edge where MemReady=1.
- When undefined: no port; memory is treated as always ready; timing is exactly as above.

Test Plan:
- Reset release, Op=0000011 held -> State 0,1,2,3,4,0. IRWrite=1 in cycle 0 only; RegWrite=1 with ResultSrc=01 in cycle 4; 5-cycle period.
- Op=0100011 -> State 0,1,2,5,0. MemWrite=1 and AdrSrc=1 only in MEMWRITE; RegWrite never 1; ImmSrc=01 throughout.
- Op=1100011: run once with Zero=1 and once with Zero=0 in BEQ -> PCWrite=1 in BEQ only when Zero=1; ALUOp=01; return to FETCH after 3 cycles.
- Op=1101111 -> State 0,1,9,7,0. PCWrite=1 in FETCH and JAL; RegWrite=1 in ALUWB with ResultSrc=00; ImmSrc=11.
- Op=0110011 then Op=0010011 -> State 6 (ALUSrcB=00) and State 8 (ALUSrcB=01) respectively, each followed by ALUWB. Op=1111111 -> DECODE then FETCH with no write enables.
- rst_n pulsed low asynchronously during MEMWRITE -> MemWrite drops before the next clk edge. State=0; write enables stay 0 until release.
- With MCU_MEM_WAIT_EN defined, MemReady=0 for 3 cycles in FETCH -> State stays 0; PCWrite=0 and IRWrite=0 until MemReady=1, then DECODE next cycle.
